// File: rtl/msx_mouse_port_ctrl.sv
// Shares one MSX general-purpose port between the joystick and a PS/2 mouse (MSX nibble protocol).
// Latency: port_o updates one clk_sys after the input/strobe change; no backpressure (strobe-driven).
module msx_mouse_port_ctrl #(
    parameter int TIMEOUT    = 100000,
    parameter int MOVE_SHIFT = 1,
    parameter int ACC_W      = 10
) (
    input  logic       clk_sys,
    input  logic       res_n_i,
    input  logic       mouse_strobe,
    input  logic [8:0] mouse_x,
    input  logic [8:0] mouse_y,
    input  logic [1:0] mouse_btn,
    input  logic [5:0] joy_n,
    input  logic       stra,
    output logic [5:0] port_o,
    output logic       mouse_en,
    output logic [1:0] phase_o
);
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam int AMAX = 2 ** (ACC_W - 1) - 1;
    localparam int AMIN = -(2 ** (ACC_W - 1));

    typedef enum logic [1:0] {PH_XH, PH_XL, PH_YH, PH_YL} phase_t;

    phase_t             phase_q, phase_d;
    logic               stra_q, mouse_en_q, mouse_en_d;
    logic [ACC_W-1:0]   acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [7:0]         snap_x_q, snap_x_d, snap_y_q, snap_y_d;
    logic [3:0]         nibble_q, nibble_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [5:0]         port_q, port_d;

    function automatic logic signed [31:0] sext_acc(input logic [ACC_W-1:0] a);
        return {{(32 - ACC_W){a[ACC_W-1]}}, a};
    endfunction

    function automatic logic signed [31:0] sext8(input logic [7:0] a);
        return {{24{a[7]}}, a};
    endfunction

    function automatic logic signed [31:0] sext9(input logic [8:0] a);
        return {{23{a[8]}}, a};
    endfunction

    function automatic logic [ACC_W-1:0] sat_acc(input logic signed [31:0] v);
        logic signed [31:0] r;
        r = v;
        if (v > AMAX)      r = AMAX;
        else if (v < AMIN) r = AMIN;
        return r[ACC_W-1:0];
    endfunction

    // Scaled motion clamped to the 8-bit range the MSX reads.
    function automatic logic [7:0] rep_of(input logic [ACC_W-1:0] a);
        logic signed [31:0] s;
        s = sext_acc(a) >>> MOVE_SHIFT;
        if (s > 127)       s = 127;
        else if (s < -128) s = -128;
        return s[7:0];
    endfunction

    logic               edge_det, clr;
    logic [7:0]         rep_x, rep_y;
    logic signed [31:0] ax, ay;

    assign edge_det = (stra != stra_q);
    assign clr      = (~&joy_n) && !mouse_strobe;
    assign rep_x    = rep_of(acc_x_q);
    assign rep_y    = rep_of(acc_y_q);

    always_comb begin
        phase_d    = phase_q;
        mouse_en_d = mouse_en_q;
        snap_x_d   = snap_x_q;
        snap_y_d   = snap_y_q;
        nibble_d   = nibble_q;
        tmo_d      = tmo_q;
        ax         = sext_acc(acc_x_q);
        ay         = sext_acc(acc_y_q);

        if (mouse_en_q && edge_det) begin
            unique case (phase_q)
                PH_XH: begin
                    snap_x_d = rep_x;
                    snap_y_d = rep_y;
                    // Only the reported part leaves the accumulator; the residual carries over.
                    ax       = ax - (sext8(rep_x) <<< MOVE_SHIFT);
                    ay       = ay - (sext8(rep_y) <<< MOVE_SHIFT);
                    nibble_d = rep_x[7:4];
                    phase_d  = PH_XL;
                end
                PH_XL: begin
                    nibble_d = snap_x_q[3:0];
                    phase_d  = PH_YH;
                end
                PH_YH: begin
                    nibble_d = snap_y_q[7:4];
                    phase_d  = PH_YL;
                end
                default: begin
                    nibble_d = snap_y_q[3:0];
                    phase_d  = PH_XH;
                end
            endcase
        end

        if (edge_det) begin
            tmo_d = TW'(TIMEOUT);
        end else if (tmo_q != '0) begin
            tmo_d = tmo_q - TW'(1);
            if (tmo_q == TW'(1)) phase_d = PH_XH;
        end

        if (mouse_strobe) begin
            ax         = ax - sext9(mouse_x);
            ay         = ay + sext9(mouse_y);
            mouse_en_d = 1'b1;
        end

        acc_x_d = sat_acc(ax);
        acc_y_d = sat_acc(ay);

        if (clr) begin
            mouse_en_d = 1'b0;
            phase_d    = PH_XH;
            tmo_d      = '0;
            acc_x_d    = '0;
            acc_y_d    = '0;
            nibble_d   = 4'hF;
        end

        if (mouse_en_d) port_d = {~mouse_btn[1], ~mouse_btn[0], nibble_d};
        else            port_d = stra ? 6'h3F : joy_n;
    end

    always_ff @(posedge clk_sys or negedge res_n_i) begin
        if (!res_n_i) begin
            phase_q    <= PH_XH;
            stra_q     <= 1'b0;
            mouse_en_q <= 1'b0;
            acc_x_q    <= '0;
            acc_y_q    <= '0;
            snap_x_q   <= '0;
            snap_y_q   <= '0;
            nibble_q   <= 4'hF;
            tmo_q      <= '0;
            port_q     <= 6'h3F;
        end else begin
            phase_q    <= phase_d;
            stra_q     <= stra;
            mouse_en_q <= mouse_en_d;
            acc_x_q    <= acc_x_d;
            acc_y_q    <= acc_y_d;
            snap_x_q   <= snap_x_d;
            snap_y_q   <= snap_y_d;
            nibble_q   <= nibble_d;
            tmo_q      <= tmo_d;
            port_q     <= port_d;
        end
    end

    assign port_o   = port_q;
    assign mouse_en = mouse_en_q;
    assign phase_o  = phase_q;
endmodule

// File: tb/tb_msx_mouse_port_ctrl.sv
// Bench for msx_mouse_port_ctrl: vector table, hand sequences and random traffic against an integer model.
module tb_msx_mouse_port_ctrl;
    localparam int TO = 40;
    localparam int MS = 1;
    localparam int AW = 10;

    logic       clk_sys = 1'b0;
    logic       res_n_i = 1'b0;
    logic       mouse_strobe = 1'b0;
    logic [8:0] mouse_x = '0, mouse_y = '0;
    logic [1:0] mouse_btn = '0;
    logic [5:0] joy_n = 6'h3F;
    logic       stra = 1'b0;
    logic [5:0] port_o;
    logic       mouse_en;
    logic [1:0] phase_o;

    int n_chk = 0;
    int n_err = 0;

    msx_mouse_port_ctrl #(.TIMEOUT(TO), .MOVE_SHIFT(MS), .ACC_W(AW)) dut (
        .clk_sys(clk_sys), .res_n_i(res_n_i), .mouse_strobe(mouse_strobe),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_btn(mouse_btn),
        .joy_n(joy_n), .stra(stra), .port_o(port_o), .mouse_en(mouse_en),
        .phase_o(phase_o)
    );

    always #5 clk_sys = ~clk_sys;

    // Model state kept as plain integers.
    int m_accx, m_accy, m_snx, m_sny, m_nib, m_tmo, m_phase;
    bit m_en, m_straq;
    logic [5:0] m_port;

    function automatic int clampi(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int rep(int a);
        return clampi(a >>> MS, -128, 127);
    endfunction

    task automatic model_reset();
        m_accx = 0; m_accy = 0; m_snx = 0; m_sny = 0; m_nib = 15;
        m_tmo = 0; m_phase = 0; m_en = 0; m_straq = 0; m_port = 6'h3F;
    endtask

    task automatic model_step();
        bit e, clr;
        int ax, ay, rx, ry, nph;
        e   = (stra != m_straq);
        clr = (joy_n != 6'h3F) && !mouse_strobe;
        ax  = m_accx; ay = m_accy; nph = m_phase;
        if (m_en && e) begin
            case (m_phase)
                0: begin
                    rx = rep(m_accx); ry = rep(m_accy);
                    ax = ax - rx * (1 << MS); ay = ay - ry * (1 << MS);
                    m_nib = (rx & 255) >> 4;
                    m_snx = rx; m_sny = ry;
                end
                1: m_nib = m_snx & 15;
                2: m_nib = (m_sny & 255) >> 4;
                default: m_nib = m_sny & 15;
            endcase
            nph = (m_phase + 1) % 4;
        end
        if (e) m_tmo = TO;
        else if (m_tmo > 0) begin
            if (m_tmo == 1) nph = 0;
            m_tmo = m_tmo - 1;
        end
        if (mouse_strobe) begin
            ax = ax - int'($signed(mouse_x));
            ay = ay + int'($signed(mouse_y));
            m_en = 1;
        end
        m_accx = clampi(ax, -(1 << (AW - 1)), (1 << (AW - 1)) - 1);
        m_accy = clampi(ay, -(1 << (AW - 1)), (1 << (AW - 1)) - 1);
        m_phase = nph;
        if (clr) begin
            m_en = 0; m_phase = 0; m_tmo = 0; m_accx = 0; m_accy = 0; m_nib = 15;
        end
        m_straq = stra;
        if (m_en) m_port = {~mouse_btn, 4'(m_nib)};
        else      m_port = stra ? 6'h3F : joy_n;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_sys);
        model_step();
        #1;
        chk("model_port", 32'(port_o), 32'(m_port));
        chk("model_en", 32'(mouse_en), 32'(m_en));
        chk("model_phase", 32'(phase_o), 32'(m_phase));
    endtask

    task automatic toggle();
        stra = ~stra;
        cyc();
    endtask

    task automatic strobe(input logic [8:0] x, input logic [8:0] y);
        mouse_x = x; mouse_y = y; mouse_strobe = 1'b1;
        cyc();
        mouse_strobe = 1'b0;
    endtask

    task automatic clear_mode();
        joy_n = 6'h3E;
        cyc();
        joy_n = 6'h3F;
    endtask

    typedef struct {
        logic [5:0] joy;
        logic       st;
        logic       mstb;
        logic [8:0] mx;
        logic [8:0] my;
        logic [1:0] btn;
        logic [5:0] port;
        logic       en;
        logic [1:0] ph;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{6'h3E, 1'b0, 1'b0, 9'h000, 9'h000, 2'b00, 6'h3E, 1'b0, 2'd0};
        tbl[1] = '{6'h3E, 1'b1, 1'b0, 9'h000, 9'h000, 2'b00, 6'h3F, 1'b0, 2'd0};
        tbl[2] = '{6'h3F, 1'b1, 1'b1, 9'h1EC, 9'h006, 2'b00, 6'h3F, 1'b1, 2'd0};
        tbl[3] = '{6'h3F, 1'b0, 1'b0, 9'h000, 9'h000, 2'b00, 6'h30, 1'b1, 2'd1};
        tbl[4] = '{6'h3F, 1'b1, 1'b0, 9'h000, 9'h000, 2'b00, 6'h3A, 1'b1, 2'd2};
        tbl[5] = '{6'h3F, 1'b0, 1'b0, 9'h000, 9'h000, 2'b00, 6'h30, 1'b1, 2'd3};
        tbl[6] = '{6'h3F, 1'b1, 1'b0, 9'h000, 9'h000, 2'b00, 6'h33, 1'b1, 2'd0};
        tbl[7] = '{6'h3F, 1'b1, 1'b0, 9'h000, 9'h000, 2'b01, 6'h23, 1'b1, 2'd0};
        tbl[8] = '{6'h3F, 1'b0, 1'b0, 9'h000, 9'h000, 2'b00, 6'h30, 1'b1, 2'd1};

        model_reset();
        repeat (3) @(posedge clk_sys);
        #1;
        chk("reset_port", 32'(port_o), 32'h3F);
        chk("reset_en", 32'(mouse_en), 32'h0);
        chk("reset_phase", 32'(phase_o), 32'h0);
        @(negedge clk_sys);
        res_n_i = 1'b1;

        // Joystick pass-through and the basic four-nibble mouse read.
        for (int i = 0; i < 9; i++) begin
            joy_n = tbl[i].joy; stra = tbl[i].st; mouse_strobe = tbl[i].mstb;
            mouse_x = tbl[i].mx; mouse_y = tbl[i].my; mouse_btn = tbl[i].btn;
            cyc();
            chk($sformatf("vec%0d_port", i), 32'(port_o), 32'(tbl[i].port));
            chk($sformatf("vec%0d_en", i), 32'(mouse_en), 32'(tbl[i].en));
            chk($sformatf("vec%0d_phase", i), 32'(phase_o), 32'(tbl[i].ph));
        end
        mouse_strobe = 1'b0;

        // Saturation: X accumulator pins at 511, reads 0x7F twice, residual 257.
        clear_mode();
        repeat (10) strobe(9'h101, 9'h000);
        toggle(); chk("sat_xh", 32'(port_o[3:0]), 32'h7);
        toggle(); chk("sat_xl", 32'(port_o[3:0]), 32'hF);
        toggle(); toggle();
        toggle(); chk("sat_xh2", 32'(port_o[3:0]), 32'h7);
        toggle(); chk("sat_xl2", 32'(port_o[3:0]), 32'hF);

        // Revert to joystick clears accumulators; coincident strobe keeps mouse mode.
        strobe(9'h19C, 9'h000);
        joy_n = 6'h3B;
        cyc(); chk("revert_en", 32'(mouse_en), 32'h0);
        joy_n = 6'h3F;
        strobe(9'h000, 9'h000);
        toggle(); chk("revert_acc_cleared", 32'(port_o[3:0]), 32'h0);
        joy_n = 6'h3B; mouse_x = 9'h000; mouse_y = 9'h000; mouse_strobe = 1'b1;
        cyc(); chk("coincident_en", 32'(mouse_en), 32'h1);
        mouse_strobe = 1'b0; joy_n = 6'h3F;

        // Timeout: phase survives TO-1 idle cycles, returns to 0 on the next one.
        clear_mode();
        strobe(9'h1EC, 9'h006);
        toggle(); toggle();
        repeat (TO - 1) cyc();
        chk("tmo_hold_phase", 32'(phase_o), 32'h2);
        cyc();
        chk("tmo_phase", 32'(phase_o), 32'h0);
        strobe(9'h19C, 9'h000);
        toggle();
        chk("tmo_fresh_xh", 32'(port_o[3:0]), 32'h3);
        chk("tmo_fresh_phase", 32'(phase_o), 32'h1);

        // Randomized traffic, alternating fast and slow strobe rates to hit timeouts.
        for (int blk = 0; blk < 6; blk++) begin
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, (blk % 2) ? 90 : 3) == 0) stra = ~stra;
                mouse_strobe = ($urandom_range(0, 7) == 0);
                joy_n = ($urandom_range(0, 59) == 0) ? 6'($urandom) : 6'h3F;
                mouse_x = 9'($urandom); mouse_y = 9'($urandom);
                mouse_btn = 2'($urandom);
                cyc();
            end
        end
        mouse_strobe = 1'b0; joy_n = 6'h3F;

        // Asynchronous reset in the middle of a read.
        strobe(9'h1EC, 9'h006);
        toggle(); toggle();
        res_n_i = 1'b0;
        #2;
        chk("midreset_port", 32'(port_o), 32'h3F);
        chk("midreset_en", 32'(mouse_en), 32'h0);
        chk("midreset_phase", 32'(phase_o), 32'h0);
        model_reset();
        @(negedge clk_sys);
        res_n_i = 1'b1;
        repeat (4) cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
